// File: rtl/keccak_round_ctrl_if.sv
// Handshake and datapath-control bundle between a job source and the
// Keccak round controller.
interface keccak_round_ctrl_if #(
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 16
);
  logic          i_start;
  logic          o_ready;
  logic          i_abort;
  logic          o_v_enable;
  logic          o_v_load_sel;
  logic [RW-1:0] o_v_round;
  logic          o_valid;
  logic          i_ack;
  logic [CW-1:0] o_v_count;

  modport master (
    output i_start, i_abort, i_ack,
    input  o_ready, o_v_enable, o_v_load_sel, o_v_round, o_valid, o_v_count
  );

  modport slave (
    input  i_start, i_abort, i_ack,
    output o_ready, o_v_enable, o_v_load_sel, o_v_round, o_valid, o_v_count
  );
endinterface

// File: rtl/keccak_round_ctrl.sv
// Keccak permutation sequencer: loads the state register once, runs
// ROUNDS round-function updates, then holds the result until acknowledged.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
module keccak_round_ctrl #(
  parameter int unsigned ROUNDS = 24,
  parameter int unsigned RW     = 5,
  parameter int unsigned CW     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  keccak_round_ctrl_if.slave bus
);

  if (ROUNDS < 1 || ROUNDS > (32'd1 << RW)) begin : g_bad_rounds
    $error("keccak_round_ctrl: ROUNDS must lie in 1..2**RW");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROUND,
    HOLD
  } state_t;

  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  state_t        state;
  logic [RW-1:0] round;
  logic [CW-1:0] count;
  logic          ready;
  logic          enable;
  logic          load_sel;
  logic          valid;

  // An abort only matters once a job is in flight; in IDLE it just
  // suppresses a coincident start.
  logic abort_job;
  assign abort_job = bus.i_abort && (state != IDLE);

  // Sequencer: each transition also sets the outputs of the state being
  // entered, which keeps every output registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      round    <= '0;
      count    <= '0;
      ready    <= 1'b1;
      enable   <= 1'b0;
      load_sel <= 1'b0;
      valid    <= 1'b0;
    end else if (abort_job) begin
      state    <= IDLE;
      round    <= '0;
      ready    <= 1'b1;
      enable   <= 1'b0;
      load_sel <= 1'b0;
      valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start && !bus.i_abort) begin
            state    <= LOAD;
            round    <= '0;
            ready    <= 1'b0;
            enable   <= 1'b1;
            load_sel <= 1'b1;
          end
        end
        LOAD: begin
          state    <= ROUND;
          round    <= '0;
          load_sel <= 1'b0;
        end
        ROUND: begin
          if (round == LAST_ROUND) begin
            state  <= HOLD;
            round  <= '0;
            enable <= 1'b0;
            valid  <= 1'b1;
          end else begin
            round <= round + 1'b1;
          end
        end
        HOLD: begin
          if (bus.i_ack) begin
            state <= IDLE;
            valid <= 1'b0;
            ready <= 1'b1;
            count <= count + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          round    <= '0;
          ready    <= 1'b1;
          enable   <= 1'b0;
          load_sel <= 1'b0;
          valid    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_v_enable   = enable;
  assign bus.o_v_load_sel = load_sel;
  assign bus.o_v_round    = round;
  assign bus.o_valid      = valid;
  assign bus.o_v_count    = count;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Bench for keccak_round_ctrl: three instances (default, CW=2 with a full
// round-index range, ROUNDS=1). The driver pushes the expected output
// vector for each cycle into a scoreboard; a monitor pops and compares it
// one time unit after the following rising edge.
module tb_keccak_round_ctrl;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] start_v;
  logic [2:0] abort_v;
  logic [2:0] ack_v;
  logic [2:0] rst_v;

  keccak_round_ctrl_if #(.RW(5), .CW(16)) if0 ();
  keccak_round_ctrl_if #(.RW(2), .CW(2))  if1 ();
  keccak_round_ctrl_if #(.RW(1), .CW(16)) if2 ();

  assign if0.i_start = start_v[0];
  assign if0.i_abort = abort_v[0];
  assign if0.i_ack   = ack_v[0];
  assign if1.i_start = start_v[1];
  assign if1.i_abort = abort_v[1];
  assign if1.i_ack   = ack_v[1];
  assign if2.i_start = start_v[2];
  assign if2.i_abort = abort_v[2];
  assign if2.i_ack   = ack_v[2];

  keccak_round_ctrl #(.ROUNDS(24), .RW(5), .CW(16)) u_dut0 (
    .i_clk(clk), .i_rst(rst_v[0]), .bus(if0)
  );
  keccak_round_ctrl #(.ROUNDS(4), .RW(2), .CW(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst_v[1]), .bus(if1)
  );
  keccak_round_ctrl #(.ROUNDS(1), .RW(1), .CW(16)) u_dut2 (
    .i_clk(clk), .i_rst(rst_v[2]), .bus(if2)
  );

  // Vector layout: {ready, enable, load_sel, valid, round[4:0], count[15:0]}
  typedef struct {
    int          idx;
    logic [24:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt[3]        = '{0, 0, 0};
  int   rounds_of[3]  = '{24, 4, 1};
  int   cmask[3]      = '{65535, 3, 65535};

  task automatic check_eq(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] mk(input bit rdy, input bit en, input bit ls,
                                     input bit vld, input int r, input int c);
    return {rdy, en, ls, vld, 5'(r), 16'(c)};
  endfunction

  function automatic logic [24:0] st_idle(input int c);  return mk(1, 0, 0, 0, 0, c); endfunction
  function automatic logic [24:0] st_load(input int c);  return mk(0, 1, 1, 0, 0, c); endfunction
  function automatic logic [24:0] st_rnd(input int r, input int c); return mk(0, 1, 0, 0, r, c); endfunction
  function automatic logic [24:0] st_hold(input int c);  return mk(0, 0, 0, 1, 0, c); endfunction

  function automatic logic [24:0] obs(input int idx);
    case (idx)
      0:       return {if0.o_ready, if0.o_v_enable, if0.o_v_load_sel, if0.o_valid,
                       5'(if0.o_v_round), 16'(if0.o_v_count)};
      1:       return {if1.o_ready, if1.o_v_enable, if1.o_v_load_sel, if1.o_valid,
                       5'(if1.o_v_round), 16'(if1.o_v_count)};
      default: return {if2.o_ready, if2.o_v_enable, if2.o_v_load_sel, if2.o_valid,
                       5'(if2.o_v_round), 16'(if2.o_v_count)};
    endcase
  endfunction

  // Monitor: compare whatever the driver scheduled for this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq(e.tag, obs(e.idx), e.v);
      end
    end
  end

  // Drive one cycle's inputs on instance idx (others quiet) and schedule
  // the outputs expected after the coming edge.
  task automatic cycle(input int idx, input bit s, input bit a, input bit k,
                       input bit r, input logic [24:0] e, input string tag);
    exp_t x;
    @(negedge clk);
    start_v = '0;
    abort_v = '0;
    ack_v   = '0;
    rst_v   = '0;
    start_v[idx] = s;
    abort_v[idx] = a;
    ack_v[idx]   = k;
    rst_v[idx]   = r;
    x.idx = idx;
    x.v   = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic to_hold(input int idx, input string tag);
    cycle(idx, 1, 0, 0, 0, st_load(cnt[idx]), {tag, "_load"});
    for (int r = 0; r < rounds_of[idx]; r++)
      cycle(idx, 0, 0, 0, 0, st_rnd(r, cnt[idx]), {tag, "_round"});
    cycle(idx, 0, 0, 0, 0, st_hold(cnt[idx]), {tag, "_hold"});
  endtask

  task automatic ack_job(input int idx, input bit s, input string tag);
    cnt[idx] = (cnt[idx] + 1) & cmask[idx];
    cycle(idx, s, 0, 1, 0, st_idle(cnt[idx]), tag);
  endtask

  initial begin
    start_v = '0;
    abort_v = '0;
    ack_v   = '0;
    rst_v   = '1;
    repeat (2) @(posedge clk);

    // reset values of each instance
    for (int i = 0; i < 3; i++)
      cycle(i, 1, 1, 1, 1, st_idle(0), "reset");

    // full job, long hold with stray starts, ack, stray ack in idle
    to_hold(0, "job1");
    repeat (10) cycle(0, 1, 0, 0, 0, st_hold(cnt[0]), "hold_wait");
    ack_job(0, 0, "ack1");
    cycle(0, 0, 0, 1, 0, st_idle(cnt[0]), "ack_in_idle");

    // abort at round 7, with start and ack noise during rounds
    cycle(0, 1, 0, 0, 0, st_load(cnt[0]), "ab_load");
    for (int r = 0; r <= 7; r++)
      cycle(0, (r == 4), 0, (r == 5), 0, st_rnd(r, cnt[0]), "ab_round");
    cycle(0, 1, 1, 0, 0, st_idle(cnt[0]), "abort_r7");
    cycle(0, 0, 0, 0, 0, st_idle(cnt[0]), "no_queued_start");

    // abort together with start in idle
    cycle(0, 1, 1, 0, 0, st_idle(cnt[0]), "idle_abort_start");

    // abort in LOAD
    cycle(0, 1, 0, 0, 0, st_load(cnt[0]), "al_load");
    cycle(0, 0, 1, 0, 0, st_idle(cnt[0]), "abort_load");

    // abort and ack together in HOLD
    to_hold(0, "job2");
    cycle(0, 0, 1, 1, 0, st_idle(cnt[0]), "abort_ack_hold");

    // ack with start in HOLD: start not taken, fresh start needed
    to_hold(0, "job3");
    ack_job(0, 1, "ack_with_start");
    cycle(0, 0, 0, 0, 0, st_idle(cnt[0]), "b2b_idle");
    to_hold(0, "job4");
    ack_job(0, 0, "ack4");

    // reset at round 12 with every other input asserted
    cycle(0, 1, 0, 0, 0, st_load(cnt[0]), "rs_load");
    for (int r = 0; r <= 12; r++)
      cycle(0, 0, 0, 0, 0, st_rnd(r, cnt[0]), "rs_round");
    cnt[0] = 0;
    cycle(0, 1, 1, 1, 1, st_idle(0), "reset_r12");
    cycle(0, 0, 0, 0, 0, st_idle(0), "after_reset");

    // CW=2 counter wrap: 1,2,3,0 (rounds span the full 2-bit index)
    for (int j = 0; j < 4; j++) begin
      to_hold(1, "wrap_job");
      ack_job(1, 0, "wrap_count");
    end

    // ROUNDS=1: load, single round, hold; abort beats ack
    to_hold(2, "r1");
    cycle(2, 0, 1, 1, 0, st_idle(cnt[2]), "r1_abort_ack");
    to_hold(2, "r1b");
    ack_job(2, 0, "r1_ack");

    // let the monitor drain the scoreboard, bounded
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(posedge clk);
      #2;
    end
    check_eq("drain", 25'(sb.size()), 25'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
